// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Brief    : Word-organised data RAM answering MEM-stage loads/stores with
//            programmable wait states and big-endian byte/half lanes.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  ByteSel,
  input  logic        SignExt,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Done,
  output logic        BusError
);

  localparam int          IDXW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] c_depth = 32'(DEPTH_WORDS);
  localparam logic [3:0]  c_wait  = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_count;
  logic [31:0] r_addr;
  logic [31:0] r_writeData;
  logic [1:0]  r_byteSel;
  logic        r_signExt;
  logic        r_isWrite;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic            w_req;
  logic            w_live;
  logic [31:0]     w_addr;
  logic [31:0]     w_writeData;
  logic [1:0]      w_byteSel;
  logic            w_signExt;
  logic            w_isWrite;
  logic            w_outOfRange;
  logic            w_reqError;
  logic [IDXW-1:0] w_index;
  logic [31:0]     w_curWord;
  logic [4:0]      w_bytePos;
  logic [4:0]      w_halfPos;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [31:0]     w_loadData;
  logic [31:0]     w_mergedWord;
  logic            w_enterResp;
  logic            w_doWrite;

  assign w_req = MemRead | MemWrite;
  assign Stall = ~Reset & (((r_state == IDLE) & w_req) | (r_state == WAIT));

  // A zero-wait access completes straight from IDLE, so the live inputs feed the datapath there.
  assign w_live      = (r_state == IDLE);
  assign w_addr      = w_live ? Address   : r_addr;
  assign w_writeData = w_live ? WriteData : r_writeData;
  assign w_byteSel   = w_live ? ByteSel   : r_byteSel;
  assign w_signExt   = w_live ? SignExt   : r_signExt;
  assign w_isWrite   = w_live ? MemWrite  : r_isWrite;

  assign w_outOfRange = (Address < ADDR_BASE) ||
                        (((Address - ADDR_BASE) >> 2) >= c_depth);
  assign w_reqError   = (ByteSel == 2'b11) ||
                        ((ByteSel == 2'b00) && (Address[1:0] != 2'b00)) ||
                        ((ByteSel == 2'b01) && Address[0]) ||
                        w_outOfRange ||
                        (MemRead && MemWrite);

  assign w_index   = IDXW'((w_addr - ADDR_BASE) >> 2);
  assign w_curWord = r_mem[w_index];
  assign w_bytePos = {~w_addr[1:0], 3'b000};
  assign w_halfPos = {~w_addr[1], 4'b0000};
  assign w_byte    = w_curWord[w_bytePos +: 8];
  assign w_half    = w_curWord[w_halfPos +: 16];

  always_comb begin
    w_loadData   = 32'd0;
    w_mergedWord = w_curWord;
    case (w_byteSel)
      2'b00: begin
        w_loadData   = w_curWord;
        w_mergedWord = w_writeData;
      end
      2'b01: begin
        w_loadData = {{16{w_signExt & w_half[15]}}, w_half};
        w_mergedWord[w_halfPos +: 16] = w_writeData[15:0];
      end
      2'b10: begin
        w_loadData = {{24{w_signExt & w_byte[7]}}, w_byte};
        w_mergedWord[w_bytePos +: 8] = w_writeData[7:0];
      end
      default: begin
        w_loadData   = 32'd0;
        w_mergedWord = w_curWord;
      end
    endcase
  end

  assign w_enterResp = ((r_state == IDLE) && w_req && !w_reqError && (WAIT_STATES == 0)) ||
                       ((r_state == WAIT) && (r_count == 4'd1));
  assign w_doWrite   = w_enterResp & w_isWrite & ~Reset;

  always_ff @(posedge Clock) begin
    if (w_doWrite) begin
      r_mem[w_index] <= w_mergedWord;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_count     <= 4'd0;
      r_addr      <= 32'd0;
      r_writeData <= 32'd0;
      r_byteSel   <= 2'b00;
      r_signExt   <= 1'b0;
      r_isWrite   <= 1'b0;
      ReadData    <= 32'd0;
      Done        <= 1'b0;
      BusError    <= 1'b0;
    end else begin
      Done     <= 1'b0;
      BusError <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_addr      <= Address;
            r_writeData <= WriteData;
            r_byteSel   <= ByteSel;
            r_signExt   <= SignExt;
            r_isWrite   <= MemWrite;
            if (w_reqError) begin
              r_state  <= RESP;
              Done     <= 1'b1;
              BusError <= 1'b1;
              ReadData <= 32'd0;
            end else if (WAIT_STATES == 0) begin
              r_state  <= RESP;
              Done     <= 1'b1;
              ReadData <= w_isWrite ? 32'd0 : w_loadData;
            end else begin
              r_count <= c_wait;
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (r_count == 4'd1) begin
            r_state  <= RESP;
            Done     <= 1'b1;
            ReadData <= r_isWrite ? 32'd0 : w_loadData;
          end else begin
            r_count <= r_count - 4'd1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
